fpcvt_arbiter: RTL and testbench
================================

# fpcvt_arbiter

Round-robin scheduler that shares one combinational FPCVT converter (12-bit two's complement in; sign, 3-bit exponent, 4-bit significand out) among NUM_REQ requesters. Sits between the requester ports and the converter. Accepts one request at a time, registers the operand, registers the converted result, and returns it tagged with the requester index over a valid/ready response port. Also keeps a count of completed conversions.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ))
- CNT_W, 16, width of completed-conversion counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  12*NUM_REQ  operand for requester i in bits [12*i+11:12*i]
- req_ready  out  NUM_REQ  one-hot grant/accept; combinational
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  ID_W  index of the requester that owns the result
- resp_s  out  1  sign
- resp_e  out  3  exponent
- resp_f  out  4  significand
- conv_count  out  CNT_W  completed conversions, saturating
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, CONV, RESP.
- IDLE:
  - Round-robin grant over req_valid, searching from pointer rr_ptr upward and wrapping at NUM_REQ-1.
  - req_ready[g] = 1 for the granted g only, and only in IDLE.
  - On accept, capture req_data slice g into op_reg, capture g into id_reg, set rr_ptr = (g+1) mod NUM_REQ, go to CONV.
  - No valid request: stay in IDLE; rr_ptr unchanged.
- CONV: FPCVT sees op_reg. Register S/E/F into resp_s/resp_e/resp_f and id_reg into resp_id. Go to RESP.
- RESP:
  - resp_valid = 1. resp_s/e/f and resp_id stay stable while resp_ready = 0.
  - On resp_valid & resp_ready, increment conv_count (saturates at all-ones) and go to IDLE.
- req_ready is 0 outside IDLE. Requests arriving then wait; a requester must hold req_valid and req_data until its req_ready.
- Reset values:
  - state = IDLE, rr_ptr = 0, op_reg = 0, id_reg = 0.
  - resp_valid = 0, resp_id = 0, resp_s = 0, resp_e = 0, resp_f = 0.
  - conv_count = 0, busy = 0.
- Reset asserted mid-operation aborts the transaction. The pending result is discarded and is not counted.

## Timing
- Accept in cycle N → resp_valid high in cycle N+2. Latency from accept edge to result is 2 cycles.
- Minimum initiation interval is 3 cycles: IDLE → CONV → RESP → IDLE. The response handshake and a new accept never occur in the same cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. A requester waits at most NUM_REQ-1 other grants.
- Simultaneous req_valid: the request nearest at or above rr_ptr wins. The others see req_ready = 0.
- conv_count at all-ones stays all-ones on further completions.

## Structure
- Shared include fpcvt_pkg.vh holds:
  - FP_IN_W = 12, FP_E_W = 3, FP_F_W = 4
  - state encodings ST_IDLE = 2'd0, ST_CONV = 2'd1, ST_RESP = 2'd2
- Sub-module rr_arbiter (NUM_REQ, ID_W):
  - inputs: req vector, rr_ptr, enable
  - outputs: one-hot grant and binary grant index
  - purely combinational
- The block instantiates one FPCVT. The FSM, registers and counter live in fpcvt_arbiter.

## Test plan
- After reset, with no requests: every output is at its reset value, busy = 0, all req_ready = 0.
- Requester 1 sends 12'd422 with resp_ready = 1: req_ready = 4'b0010 in cycle N; in cycle N+2, resp_valid = 1, resp_id = 1, S = 0, E = 5, F = 4'b1101; conv_count = 1.
- Requester 2 sends 12'hFFF; the result then returns S = 1, E = 0, F = 4'b0001. Requester 3 sends 12'h800; the result then returns S = 1, E = 7, F = 4'b1111 (saturated).
- All four requesters held valid, resp_ready = 1: grant order is 0,1,2,3,0; each result has resp_id equal to the granted index; resp_valid pulses every 3 cycles.
- Hold resp_ready = 0 for 5 cycles in RESP: outputs are stable, req_ready = 0 throughout, conv_count unchanged until resp_ready = 1.
- Pull rst_n low while in CONV: outputs go to reset values immediately with no clock edge; a later request proceeds normally and conv_count restarts from 0.

Source files
------------

// File: rtl/fpcvt_arbiter_pkg.sv
// Shared constants and types for the FPCVT round-robin scheduler.
// Converter format: 12-bit two's complement in; sign, 3-bit exponent, 4-bit significand out.
package fpcvt_arbiter_pkg;

  localparam int FP_IN_W = 12;
  localparam int FP_E_W  = 3;
  localparam int FP_F_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fpcvt_arbiter_fpcvt.sv
// Combinational FPCVT: value ~= F * 2^E, significand truncated to the four bits
// starting at the leading one; the most negative input saturates to E=7, F=1111.
module fpcvt
  import fpcvt_arbiter_pkg::*;
(
  input  logic [FP_IN_W-1:0] d_i,
  output logic               s_o,
  output logic [FP_E_W-1:0]  e_o,
  output logic [FP_F_W-1:0]  f_o
);

  logic [FP_IN_W-1:0] mag;
  int                 pos;

  always_comb begin
    s_o = d_i[FP_IN_W-1];
    mag = d_i[FP_IN_W-1] ? (~d_i + FP_IN_W'(1)) : d_i;
    // Leading-one search only above the significand; smaller values use E=0.
    pos = FP_F_W - 1;
    for (int i = FP_F_W; i < FP_IN_W - 1; i++) begin
      if (mag[i]) pos = i;
    end
    if (mag[FP_IN_W-1]) begin
      e_o = '1;
      f_o = '1;
    end else begin
      e_o = FP_E_W'(pos - (FP_F_W - 1));
      f_o = FP_F_W'(mag >> (pos - (FP_F_W - 1)));
    end
  end

endmodule

// File: rtl/fpcvt_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or above
// ptr_i (wrapping at NUM_REQ-1) wins; nothing is granted while en_i is low.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpcvt_arbiter.sv
// Round-robin scheduler sharing one FPCVT among NUM_REQ requesters, with a
// registered operand, registered tagged result and a saturating completion count.
module fpcvt_arbiter
  import fpcvt_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [FP_IN_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic                       resp_s,
  output logic [FP_E_W-1:0]          resp_e,
  output logic [FP_F_W-1:0]          resp_f,
  output logic [CNT_W-1:0]           conv_count,
  output logic                       busy,
  output state_e                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high. Requesters hold valid/data until ready; ready never depends on a later
  // cycle; resp_* is held stable from resp_valid rising until the transfer.

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [FP_IN_W-1:0]   op_q, op_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      resp_id_q, resp_id_d;
  logic                 resp_s_q, resp_s_d;
  logic [FP_E_W-1:0]    resp_e_q, resp_e_d;
  logic [FP_F_W-1:0]    resp_f_q, resp_f_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [ID_W-1:0]      gnt_idx;
  logic [FP_IN_W-1:0]   op_sel;
  logic                 cv_s;
  logic [FP_E_W-1:0]    cv_e;
  logic [FP_F_W-1:0]    cv_f;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .en_i      (state_q == ST_IDLE),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  fpcvt u_cvt (
    .d_i (op_q),
    .s_o (cv_s),
    .e_o (cv_e),
    .f_o (cv_f)
  );

  assign op_sel = req_data[int'(gnt_idx)*FP_IN_W +: FP_IN_W];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    resp_s_d  = resp_s_q;
    resp_e_d  = resp_e_q;
    resp_f_d  = resp_f_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          op_d     = op_sel;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        resp_s_d  = cv_s;
        resp_e_d  = cv_e;
        resp_f_d  = cv_f;
        resp_id_d = id_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      op_q      <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      resp_s_q  <= 1'b0;
      resp_e_q  <= '0;
      resp_f_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      op_q      <= op_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      resp_s_q  <= resp_s_d;
      resp_e_q  <= resp_e_d;
      resp_f_q  <= resp_f_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_id    = resp_id_q;
  assign resp_s     = resp_s_q;
  assign resp_e     = resp_e_q;
  assign resp_f     = resp_f_q;
  assign conv_count = cnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fpcvt_arbiter.sv
// Self-checking bench for fpcvt_arbiter: directed cases from the test plan plus
// randomized traffic against a transaction-level reference model.
module tb_fpcvt_arbiter;
  import fpcvt_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;
  localparam int RW    = ID_W + 1 + FP_E_W + FP_F_W;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [FP_IN_W*N-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_s;
  logic [FP_E_W-1:0]    resp_e;
  logic [FP_F_W-1:0]    resp_f;
  logic [CNT_W-1:0]     conv_count;
  logic                 busy;
  state_e               dbg_state;

  fpcvt_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_s     (resp_s),
    .resp_e     (resp_e),
    .resp_f     (resp_f),
    .conv_count (conv_count),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [RW-1:0]      exp_q[$];
  bit                 pend_v[N];
  logic [FP_IN_W-1:0] pend_d[N];
  int                 ptr;
  int                 n_done;
  int                 n_total;
  int                 n_pass;
  int                 n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: repeated halving until the magnitude fits in 4 bits.
  function automatic logic [7:0] fp_ref(input logic [11:0] d);
    int   v, m, e;
    logic s;
    v = int'($signed(d));
    s = (v < 0);
    m = s ? -v : v;
    if (m >= 2048) return {1'b1, 3'd7, 4'hF};
    e = 0;
    while (m >= 16) begin
      m = m / 2;
      e++;
    end
    return {s, 3'(e), 4'(m)};
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (pend_v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // driver
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]                    = pend_v[i];
      req_data[i*FP_IN_W +: FP_IN_W]  = pend_d[i];
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
  endtask

  // One full transaction starting ~1ns after a rising edge with the DUT idle.
  // hold = cycles resp_ready stays low in RESP; keep = granted requester stays valid.
  task automatic run_txn(input int hold, input bit keep, output int g);
    logic [N-1:0]  oh;
    logic [RW-1:0] exp;
    apply();
    g  = model_grant();
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'(oh));
    check("idle_busy", 32'(busy), 32'd0);
    if (g < 0) return;
    exp = {ID_W'(g), fp_ref(pend_d[g])};
    exp_q.push_back(exp);
    @(posedge clk); #1;
    ptr = (g + 1) % N;
    if (keep) pend_d[g] = 12'($urandom_range(0, 4095));
    else pend_v[g] = 1'b0;
    apply();
    @(negedge clk);
    check("conv_req_ready", 32'(req_ready), 32'd0);
    check("conv_resp_valid", 32'(resp_valid), 32'd0);
    check("conv_state", 32'(dbg_state), 32'(ST_CONV));
    @(posedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      resp_ready = (h == hold);
      @(negedge clk);
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("resp_req_ready", 32'(req_ready), 32'd0);
      check("resp_payload", 32'({resp_id, resp_s, resp_e, resp_f}), 32'(exp_q[0]));
      check("resp_count_hold", 32'(conv_count), 32'(n_done));
      @(posedge clk); #1;
    end
    void'(exp_q.pop_front());
    n_done++;
    resp_ready = 1'b0;
    check("done_count", 32'(conv_count), 32'(n_done));
    check("done_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_count"}, 32'(conv_count), 32'd0);
    check({tag, "_payload"}, 32'({resp_id, resp_s, resp_e, resp_f}), 32'd0);
  endtask

  initial begin
    int g;
    n_total = 0; n_pass = 0; n_fail = 0; n_done = 0; ptr = 0;
    rst_n = 1'b0; resp_ready = 1'b0;
    req_valid = '0; req_data = '0;
    clear_pend();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_reset_idle");

    // directed conversions from the test plan
    pend_v[1] = 1'b1; pend_d[1] = 12'd422;
    run_txn(0, 1'b0, g);
    pend_v[2] = 1'b1; pend_d[2] = 12'hFFF;
    run_txn(0, 1'b0, g);
    pend_v[3] = 1'b1; pend_d[3] = 12'h800;
    run_txn(0, 1'b0, g);
    pend_v[0] = 1'b1; pend_d[0] = 12'h7FF;
    run_txn(0, 1'b0, g);

    // fairness: all requesters continuously valid, back-to-back responses
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b1;
      pend_d[i] = 12'($urandom_range(0, 4095));
    end
    for (int k = 0; k < 5; k++) run_txn(0, 1'b1, g);
    clear_pend();

    // consumer back-pressure for 5 cycles
    pend_v[2] = 1'b1; pend_d[2] = 12'h123;
    run_txn(5, 1'b0, g);

    // randomized traffic with random back-pressure and boundary operands
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) begin
          pend_v[i] = 1'b1;
          case ($urandom_range(0, 7))
            0:       pend_d[i] = 12'h000;
            1:       pend_d[i] = 12'h800;
            2:       pend_d[i] = 12'h7FF;
            3:       pend_d[i] = 12'hFFF;
            default: pend_d[i] = 12'($urandom_range(0, 4095));
          endcase
        end
      end
      if (model_grant() < 0) begin
        g = $urandom_range(0, N - 1);
        pend_v[g] = 1'b1;
        pend_d[g] = 12'($urandom_range(0, 4095));
      end
      run_txn($urandom_range(0, 2), 1'b0, g);
    end
    clear_pend();
    apply();

    // reset while in CONV aborts the transaction
    pend_v[0] = 1'b1; pend_d[0] = 12'h0A5;
    apply();
    @(negedge clk);
    check("abort_grant", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    clear_pend();
    apply();
    check("abort_in_conv", 32'(dbg_state), 32'(ST_CONV));
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    ptr = 0; n_done = 0;
    exp_q.delete();
    @(posedge clk); #1;
    pend_v[1] = 1'b1; pend_d[1] = 12'hF00;
    pend_v[3] = 1'b1; pend_d[3] = 12'h0FF;
    run_txn(1, 1'b0, g);
    run_txn(0, 1'b0, g);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
